// File: rtl/osd_trace_pkg.sv
// Shared constants and helpers for the trace arbiter slice.
package osd_trace_pkg;
  localparam int DROPCNT_WIDTH = 16;

  function automatic int src_tag_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/osd_rr_arbiter.sv
// Round-robin grant over N requesters; search starts one past the last winner.
module osd_rr_arbiter
  import osd_trace_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int IW = src_tag_width(N);

  logic [IW-1:0] r_last;
  logic [IW-1:0] w_win;
  logic          w_hit;
  int            w_idx;

  always_comb begin
    grant = '0;
    w_win = r_last;
    w_hit = 1'b0;
    w_idx = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(r_last) + k) % N;
      if (!w_hit && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_win        = IW'(w_idx);
        w_hit        = 1'b1;
      end
    end
  end

  // Pointer parks on N-1 so source 0 is first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_last <= IW'(N - 1);
    else if (advance) r_last <= w_win;
  end
endmodule

// File: rtl/osd_trace_arbiter.sv
// Shares one trace packetization path between N sample sources, tagging words with the source index.
// Optional drop accounting is enabled with `define OSD_TRACE_ARB_DROPCNT_EN.
module osd_trace_arbiter
  import osd_trace_pkg::*;
#(
  parameter int N     = 2,
  parameter int WIDTH = 34,
  parameter int SRCW  = src_tag_width(N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               src_enable,
  input  logic [N*WIDTH-1:0]         in_data,
  input  logic [N-1:0]               in_overflow,
  input  logic [N-1:0]               in_valid,
  output logic [N-1:0]               in_ready,
  output logic [SRCW+WIDTH-1:0]      out_data,
  output logic                       out_overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*DROPCNT_WIDTH-1:0] drop_count
);
  logic                  r_valid;
  logic [SRCW+WIDTH-1:0] r_data;
  logic                  r_ovf;

  logic                  w_load;
  logic                  w_adv;
  logic [N-1:0]          w_req;
  logic [N-1:0]          w_grant;
  logic [SRCW-1:0]       w_tag;
  logic [WIDTH-1:0]      w_pl;
  logic                  w_ovf;

  assign w_load = !r_valid | out_ready;
  assign w_req  = in_valid & src_enable;
  assign w_adv  = w_load & (|w_req);

  osd_rr_arbiter #(.N(N)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_adv),
    .grant   (w_grant)
  );

  // Muted sources are always drained so they never stall their tracer.
  assign in_ready = (w_grant & {N{w_load}}) | ~src_enable;

  always_comb begin
    w_tag = '0;
    w_pl  = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_tag = SRCW'(i);
        w_pl  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef OSD_TRACE_ARB_DROPCNT_EN
  logic [N-1:0]                    r_pend;
  logic [N-1:0][DROPCNT_WIDTH-1:0] r_drop;
  logic [N-1:0]                    w_drop;
  logic [N-1:0]                    w_acc;

  assign w_drop     = in_valid & ~src_enable;
  assign w_acc      = w_grant & {N{w_adv}};
  assign w_ovf      = |(w_grant & (in_overflow | r_pend));
  assign drop_count = r_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_drop <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_drop[i]) begin
          r_pend[i] <= 1'b1;
          if (r_drop[i] != '1) r_drop[i] <= r_drop[i] + 1'b1;
        end else if (w_acc[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end
`else
  assign w_ovf      = |(w_grant & in_overflow);
  assign drop_count = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_valid <= |w_req;
      if (|w_req) begin
        r_data <= {w_tag, w_pl};
        r_ovf  <= w_ovf;
      end
    end
  end

  assign out_valid    = r_valid;
  assign out_data     = r_data;
  assign out_overflow = r_ovf;
endmodule

// File: doc/osd_trace_arbiter.md
# osd_trace_arbiter

Round-robin arbiter that shares one trace packetization path (FIFO → `osd_trace_packetization`) between `N` trace sample sources, such as several `osd_tracesample` instances inside one trace module. It tags every accepted word with its source index and forwards the per-word overflow flag. Per-source enables let software mute a source. A muted source's samples are drained and accounted for, so the muted source never back-pressures its tracer. The block sits between the per-source sample FIFOs and the single packetization input.

## Interface
- `N`, 2: number of sources, 2..16.
- `WIDTH`, 34: payload width per source word.
- `SRCW`, `$clog2(N)`: source tag width, minimum 1.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `src_enable`  in  N: per-source enable, from register access; sampled every cycle.
- `in_data`  in  N×WIDTH: packed source payloads; source i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_overflow`  in  N: per-source overflow flag accompanying `in_data`.
- `in_valid`  in  N: per-source valid.
- `in_ready`  out  N: per-source ready.
- `out_data`  out  SRCW+WIDTH: `{src_idx, payload}`.
- `out_overflow`  out  1: overflow flag of the forwarded word.
- `out_valid`  out  1: output valid.
- `out_ready`  in  1: output ready.
- `drop_count`  out  N×16: per-source dropped-word counters.

## Operation
- Handshake: a transfer happens when `valid & ready` on a cycle edge.
- Once `out_valid` is asserted, `out_data` and `out_overflow` stay stable until accepted.
- Output register (OREG) is one entry holding data, overflow and valid.
- `load = !out_valid | out_ready`.
- Requesters: `req[i] = in_valid[i] & src_enable[i]`.
- Winner selection: when `load` is true and any `req` is set, the winner is the first set `req` searching from `(last+1) mod N` upward with wrap.
- The winner gets `in_ready[winner]=1` in the same cycle. OREG loads the winner's word and `last <= winner`.
- Disabled sources: `in_ready[i]=1` whenever `src_enable[i]=0`, so the source is drained.
  - Each drained word with `in_valid[i]=1` increments `drop_count[i]`, saturating at 16'hFFFF.
  - Each drained word also sets sticky `pend_ovf[i]`.
- On acceptance of a word from source i: `out_overflow = in_overflow[i] | pend_ovf[i]`, and `pend_ovf[i]` is cleared in the same cycle.
  - If a drop and an acceptance hit the same source in one cycle, the set wins. This cannot happen, because enable is a single value per cycle.
- Enable change:
  - A word already in OREG is always delivered, regardless of `src_enable`.
  - Enable takes effect combinationally from the next arbitration decision.
- `drop_count` is never cleared except by `rst`.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_overflow=0`.
  - `last=N-1`, so source 0 wins first.
  - `pend_ovf=0`, `drop_count=0`.
  - `in_ready` follows its combinational equations.
- Latency is 1 cycle from source acceptance to `out_valid`.
- Throughput is one word per cycle while `out_ready=1`.
- `in_ready` depends combinationally on `out_valid`, `out_ready`, `in_valid`, `src_enable` and `last`. There is no combinational path from `in_data` to any output.
- Fairness: under continuous requests from all N sources, each source is granted exactly once every N accepted words.
- Output stalled (`out_valid=1`, `out_ready=0`): all enabled `in_ready=0`, and `last` is unchanged.
- Reset asserted mid-transfer: OREG contents are discarded immediately. No partial state survives.

## Configuration
- `OSD_TRACE_ARB_DROPCNT_EN`
  - Defined: drop counters and `pend_ovf` are implemented as described above.
  - Not defined: `drop_count` is tied to 0, `pend_ovf` is absent, and `out_overflow = in_overflow[winner]`. Draining of disabled sources is unchanged.

## Structure
- Shared package `osd_trace_pkg` holds:
  - the `DROPCNT_WIDTH=16` constant;
  - a `src_tag_width(N)` function returning `max(1,$clog2(N))`.
- Sub-module `osd_rr_arbiter`, parameterised on `N`:
  - inputs `req`, `advance`; output one-hot `grant`;
  - holds the `last` pointer;
  - updates `last` only when `advance` (`load` and any req) is true.
- `osd_trace_arbiter` instantiates `osd_rr_arbiter` and contains OREG, drop counters and `pend_ovf`.

## Test plan
- **Fair sharing.** N=2, both valid continuously, `out_ready=1`, both enabled → `out_data` tags alternate 0,1,0,1. First word appears 1 cycle after reset release.
- **Backpressure.** `out_ready=0` for 5 cycles with OREG full → `in_ready=2'b00`, `out_data` stable. On release, the next grant goes to the source after the last winner.
- **Mute and drop.** `src_enable=2'b01`, source 1 presents 3 words → `in_ready[1]=1`, `drop_count[1]=3`. Re-enable and send one word with `in_overflow=0` → forwarded with `out_overflow=1`, and the next word from source 1 has `out_overflow=0`.
- **Saturation.** Drop 65540 words on source 0 → `drop_count[0]=16'hFFFF`.
- **Disable while held.** Source 0 word in OREG, `out_ready=0`, then `src_enable[0]` goes to 0 → the word is still delivered with tag 0 when `out_ready=1`.
- **Async reset mid-stream.** Assert `rst` between clock edges with `out_valid=1` → `out_valid=0` immediately. After release, source 0 is granted first.
